fft8_frame_ctrl: RTL and testbench

Frame sequencer for the 8-point combinational FFT core with `sel`-muxed, registered output. Accepts a serial stream of complex samples over a valid/ready handshake and buffers one 8-sample frame. Drives the buffered frame onto the core's parallel input buses, then steps the core's `sel` to stream the eight results out over a second valid/ready handshake. Sits between the sample source and the result sink; it is the only block that drives the core's `sel` and input buses.

---
 rtl/fft8_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// rtl/fft8_frame_ctrl.sv - frame sequencer for the 8-point sel-muxed FFT core
// Purpose: buffers 8-sample frames from a valid/ready stream, presents the
// buffered frame on the core input buses, then steps core_sel so the core's
// registered result streams out one bin per cycle.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       synchronous abort, discards all buffered data
//   in_valid_i, in_ready_o        sample handshake; in_r_i / in_i_i sample
//   out_valid_o, out_ready_i      result handshake; out_r_o / out_i_o result
//   out_idx_o, out_last_o         bin index of current result, high on bin 7
//   core_xr_o, core_xi_o          core inputs, sample k at [k*W +: W]
//   core_sel_o, core_rst_o        core result select, active-high core reset
//   core_yr_i, core_yi_i          core registered result
// Macro FFT8_FRAME_CTRL_PINGPONG_EN: two sample banks so loading the next frame
// overlaps unloading the current one; undefined builds a single bank.
module fft8_frame_ctrl #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   in_r_i,
    input  logic [W-1:0]   in_i_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W-1:0]   out_r_o,
    output logic [W-1:0]   out_i_o,
    output logic [2:0]     out_idx_o,
    output logic           out_last_o,
    output logic [8*W-1:0] core_xr_o,
    output logic [8*W-1:0] core_xi_o,
    output logic [2:0]     core_sel_o,
    output logic           core_rst_o,
    input  logic [W-1:0]   core_yr_i,
    input  logic [W-1:0]   core_yi_i
);
    typedef enum logic [1:0] {LOAD, SETTLE, UNLOAD} state_t;

`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    state_t       state_q;
    logic [2:0]   cnt_q;           // write position in the load bank
    logic [2:0]   k_q;             // bin currently presented
    logic [1:0]   full_q;          // per-bank full flag
    logic         lb_q;            // bank receiving samples
    logic         cb;              // bank driving the core
    logic [W-1:0] xr_q [2][8];
    logic [W-1:0] xi_q [2][8];

    logic in_fire, last_fire, out_fire, frame_done, swap;

    // In the single-bank build both roles share bank 0 and lb_q never moves.
    assign cb          = PINGPONG ? ~lb_q : lb_q;
    assign in_ready_o  = ~full_q[lb_q];
    assign in_fire     = in_valid_i & in_ready_o;
    assign last_fire   = in_fire & (cnt_q == 3'd7);
    assign out_valid_o = (state_q == UNLOAD);
    assign out_fire    = out_valid_o & out_ready_i;
    assign frame_done  = out_fire & (k_q == 3'd7);
    // Chain straight into the next frame if the load bank is (or just became) full.
    assign swap        = PINGPONG & frame_done & (full_q[lb_q] | last_fire);

    assign out_r_o    = core_yr_i;
    assign out_i_o    = core_yi_i;
    assign out_idx_o  = k_q;
    assign out_last_o = out_valid_o & (k_q == 3'd7);
    assign core_rst_o = ~rst_ni;

    // Look one bin ahead on a handshake so the core's registered output is
    // already the next bin when k advances; on a stall it re-latches bin k.
    always_comb begin
        core_sel_o = 3'd0;
        if (state_q == UNLOAD) begin
            core_sel_o = (out_ready_i && k_q != 3'd7) ? k_q + 3'd1 : k_q;
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_bus
        assign core_xr_o[n*W +: W] = xr_q[cb][n];
        assign core_xi_o[n*W +: W] = xi_q[cb][n];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            k_q     <= '0;
            full_q  <= '0;
            lb_q    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < 8; n++) begin
                    xr_q[b][n] <= '0;
                    xi_q[b][n] <= '0;
                end
            end
        end else if (flush_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            k_q     <= '0;
            full_q  <= '0;
            lb_q    <= 1'b0;
        end else begin
            if (in_fire) begin
                xr_q[lb_q][cnt_q] <= in_r_i;
                xi_q[lb_q][cnt_q] <= in_i_i;
                cnt_q             <= cnt_q + 3'd1;  // wraps to 0 on the 8th beat
            end
            if (last_fire) begin
                full_q[lb_q] <= 1'b1;
            end
            if (frame_done) begin
                full_q[cb] <= 1'b0;
            end
            case (state_q)
                LOAD: begin
                    if (last_fire) begin
                        state_q <= SETTLE;
                        if (PINGPONG) begin
                            lb_q <= ~lb_q;
                        end
                    end
                end
                SETTLE: begin
                    state_q <= UNLOAD;
                    k_q     <= '0;
                end
                UNLOAD: begin
                    if (out_fire) begin
                        k_q <= k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            if (swap) begin
                                state_q <= SETTLE;
                                lb_q    <= ~lb_q;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb/tb_fft8_frame_ctrl.sv - self-checking bench for fft8_frame_ctrl with a behavioural FFT core
module tb_fft8_frame_ctrl;
    localparam int  W = 8;
    localparam real R = 0.7071067811865476;
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush, in_valid, out_ready;
    logic [W-1:0]   in_r, in_i, out_r, out_i, core_yr, core_yi;
    logic           in_ready, out_valid, out_last, core_rst;
    logic [2:0]     out_idx, core_sel;
    logic [8*W-1:0] core_xr, core_xi;

    int tests = 0;
    int fails = 0;

    logic [8*W-1:0] fr_r, fr_i;
    logic [W-1:0]   cap_r [8];
    logic [W-1:0]   cap_i [8];
    logic [2:0]     cap_idx [8];
    logic           cap_last [8];
    int             cap_cyc [8];
    logic [2:0]     sel_log [16];
    int             cap_n;
    logic           post_valid, post_ready;
    logic [W-1:0]   q_r [$];
    logic [W-1:0]   q_i [$];

    fft8_frame_ctrl #(.W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_r_i(in_r), .in_i_i(in_i),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_r_o(out_r), .out_i_o(out_i),
        .out_idx_o(out_idx), .out_last_o(out_last),
        .core_xr_o(core_xr), .core_xi_o(core_xi), .core_sel_o(core_sel), .core_rst_o(core_rst),
        .core_yr_i(core_yr), .core_yi_i(core_yi)
    );

    always #5 clk = ~clk;

    function automatic real tw_c(input int m);
        case (m % 8)
            0: return 1.0;
            1: return R;
            2: return 0.0;
            3: return -R;
            4: return -1.0;
            5: return -R;
            6: return 0.0;
            default: return R;
        endcase
    endfunction

    function automatic real tw_s(input int m);
        case (m % 8)
            0: return 0.0;
            1: return R;
            2: return 1.0;
            3: return R;
            4: return 0.0;
            5: return -R;
            6: return -1.0;
            default: return -R;
        endcase
    endfunction

    // Bin k of the 8-point DFT of a packed frame, rounded and wrapped to W bits.
    function automatic logic [W-1:0] dft_bin(input logic [8*W-1:0] br, input logic [8*W-1:0] bi,
                                             input int k, input bit im);
        real acc_r, acc_i, v;
        int  a, b, q;
        acc_r = 0.0;
        acc_i = 0.0;
        for (int n = 0; n < 8; n++) begin
            a = int'($signed(br[n*W +: W]));
            b = int'($signed(bi[n*W +: W]));
            acc_r = acc_r + a * tw_c(n * k) + b * tw_s(n * k);
            acc_i = acc_i + b * tw_c(n * k) - a * tw_s(n * k);
        end
        v = im ? acc_i : acc_r;
        q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return q[W-1:0];
    endfunction

    // Behavioural core: registered result of the combinational FFT, muxed by sel.
    always @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            core_yr <= '0;
            core_yi <= '0;
        end else begin
            core_yr <= dft_bin(core_xr, core_xi, int'(core_sel), 1'b0);
            core_yi <= dft_bin(core_xr, core_xi, int'(core_sel), 1'b1);
        end
    end

    function automatic logic [8*W-1:0] rand_frame();
        logic [8*W-1:0] f;
        for (int n = 0; n < 8; n++) f[n*W +: W] = W'($urandom_range(0, 40)) - W'(20);
        return f;
    endfunction

    task automatic load_frame(input logic [8*W-1:0] xr, input logic [8*W-1:0] xi);
        int guard;
        fr_r = xr;
        fr_i = xi;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r = xr[n*W +: W];
            in_i = xi[n*W +: W];
            #1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (!in_ready) begin
                fails++;
                $display("FAIL load_timeout: in_ready=%b required 1", in_ready);
            end
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Called right after the 8th accept edge; cycle 0 is the SETTLE cycle.
    task automatic capture_frame();
        int cyc;
        cap_n = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (cap_n < 8 && cyc < 60) begin
            @(negedge clk);
            #1;
            if (cyc < 16) sel_log[cyc] = core_sel;
            if (out_valid) begin
                cap_r[cap_n] = out_r;
                cap_i[cap_n] = out_i;
                cap_idx[cap_n] = out_idx;
                cap_last[cap_n] = out_last;
                cap_cyc[cap_n] = cyc;
                cap_n++;
            end
            cyc++;
        end
        @(negedge clk);
        #1;
        post_valid = out_valid;
        post_ready = in_ready;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        tests++;
        if (out_idx !== 3'd0 || out_last !== 1'b0 || core_sel !== 3'd0) begin
            fails++;
            $display("FAIL reset_idx: idx=%0d last=%b sel=%0d required 0 0 0", out_idx, out_last, core_sel);
        end
        tests++;
        if (core_xr !== '0 || core_xi !== '0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL reset_core: xr=%h xi=%h core_rst=%b required 0 0 1", core_xr, core_xi, core_rst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (core_rst !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: core_rst=%b in_ready=%b required 0 1", core_rst, in_ready);
        end
    endtask

    task automatic test_impulse();
        load_frame(64'h01, 64'h0);
        capture_frame();
        tests++;
        if (cap_n !== 8) begin
            fails++;
            $display("FAIL imp_count: got %0d results required 8", cap_n);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if (cap_idx[b] !== 3'(b) || cap_r[b] !== 8'd1 || cap_i[b] !== 8'd0 || cap_last[b] !== (b == 7)) begin
                fails++;
                $display("FAIL imp_bin%0d: idx=%0d r=%0d i=%0d last=%b required %0d 1 0 %b",
                         b, cap_idx[b], cap_r[b], cap_i[b], cap_last[b], b, b == 7);
            end
        end
        tests++;
        if (cap_cyc[0] !== 1 || cap_cyc[7] !== 8) begin
            fails++;
            $display("FAIL imp_latency: first=%0d last=%0d required 1 8", cap_cyc[0], cap_cyc[7]);
        end
        tests++;
        if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
            fails++;
            $display("FAIL imp_after: out_valid=%b in_ready=%b required 0 1", post_valid, post_ready);
        end
    endtask

    task automatic test_dc();
        load_frame({8{8'h01}}, 64'h0);
        capture_frame();
        tests++;
        if (cap_n !== 8) begin
            fails++;
            $display("FAIL dc_count: got %0d results required 8", cap_n);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if (cap_idx[b] !== 3'(b) || cap_r[b] !== ((b == 0) ? 8'd8 : 8'd0) || cap_i[b] !== 8'd0) begin
                fails++;
                $display("FAIL dc_bin%0d: idx=%0d r=%0d i=%0d required %0d %0d 0",
                         b, cap_idx[b], cap_r[b], cap_i[b], b, (b == 0) ? 8 : 0);
            end
            tests++;
            if (sel_log[b] !== 3'(b)) begin
                fails++;
                $display("FAIL dc_sel%0d: core_sel=%0d required %0d", b, sel_log[b], b);
            end
        end
    endtask

    task automatic test_backpressure();
        int  exp_k, st2, st7, cyc;
        bit  done, rdy;
        load_frame({8{8'h01}}, 64'h0);
        exp_k = 0; st2 = 0; st7 = 0; cyc = 0; done = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_settle: out_valid=%b required 0", out_valid);
        end
        while (!done && cyc < 40) begin
            @(negedge clk);
            rdy = !((exp_k == 2 && st2 < 3) || (exp_k == 7 && st7 < 5));
            out_ready = rdy;
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 3'(exp_k) || out_r !== ((exp_k == 0) ? 8'd8 : 8'd0)
                || out_i !== 8'd0 || in_ready !== PP) begin
                fails++;
                $display("FAIL bp_cyc%0d: valid=%b idx=%0d r=%0d i=%0d in_ready=%b required 1 %0d %0d 0 %b",
                         cyc, out_valid, out_idx, out_r, out_i, in_ready, exp_k, (exp_k == 0) ? 8 : 0, PP);
            end
            if (rdy) begin
                if (exp_k == 7) done = 1'b1;
                else exp_k++;
            end else if (exp_k == 2) begin
                st2++;
            end else begin
                st7++;
            end
            cyc++;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL bp_timeout: reached bin %0d required bin 7 handshake", exp_k);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_after: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int cyc;
        bit seen;
        load_frame(64'h01, 64'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            #1;
            if (out_valid && out_idx == 3'd4) seen = 1'b1;
            cyc++;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL flush_reach: out_idx=%0d required 4", out_idx);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0) begin
            fails++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b idx=%0d required 0 1 0", out_valid, in_ready, out_idx);
        end
        load_frame(64'h01, 64'h0);
        capture_frame();
        tests++;
        if (cap_n !== 8) begin
            fails++;
            $display("FAIL flush_count: got %0d results required 8", cap_n);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if (cap_idx[b] !== 3'(b) || cap_r[b] !== 8'd1 || cap_i[b] !== 8'd0) begin
                fails++;
                $display("FAIL flush_bin%0d: idx=%0d r=%0d i=%0d required %0d 1 0", b, cap_idx[b], cap_r[b], cap_i[b], b);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r = 8'($urandom_range(1, 100));
            in_i = 8'($urandom_range(1, 100));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0
            || core_sel !== 3'd0 || core_xr !== '0 || core_xi !== '0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: rdy=%b vld=%b idx=%0d last=%b sel=%0d xr=%h xi=%h crst=%b required 1 0 0 0 0 0 0 1",
                     in_ready, out_valid, out_idx, out_last, core_sel, core_xr, core_xi, core_rst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(rand_frame(), rand_frame());
        capture_frame();
        tests++;
        if (cap_n !== 8) begin
            fails++;
            $display("FAIL rst_count: got %0d results required 8", cap_n);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if (cap_idx[b] !== 3'(b) || cap_r[b] !== dft_bin(fr_r, fr_i, b, 1'b0)
                || cap_i[b] !== dft_bin(fr_r, fr_i, b, 1'b1)) begin
                fails++;
                $display("FAIL rst_bin%0d: idx=%0d r=%0d i=%0d required %0d %0d %0d", b, cap_idx[b], cap_r[b], cap_i[b],
                         b, dft_bin(fr_r, fr_i, b, 1'b0), dft_bin(fr_r, fr_i, b, 1'b1));
            end
        end
    endtask

    task automatic test_random();
        localparam int NF = 6;
        logic [8*W-1:0] br, bi;
        int got, cyc, guard;
        q_r.delete();
        q_i.delete();
        fork
            begin
                for (int f = 0; f < NF; f++) begin
                    for (int n = 0; n < 8; n++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        @(negedge clk);
                        in_valid = 1'b1;
                        in_r = W'($urandom);
                        in_i = W'($urandom);
                        #1;
                        guard = 0;
                        while (!in_ready && guard < 200) begin
                            @(negedge clk);
                            #1;
                            guard++;
                        end
                        br[n*W +: W] = in_r;
                        bi[n*W +: W] = in_i;
                        @(posedge clk);
                        #1 in_valid = 1'b0;
                    end
                    for (int b = 0; b < 8; b++) begin
                        q_r.push_back(dft_bin(br, bi, b, 1'b0));
                        q_i.push_back(dft_bin(br, bi, b, 1'b1));
                    end
                end
            end
            begin
                got = 0;
                cyc = 0;
                while (got < NF * 8 && cyc < 3000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (out_valid && out_ready) begin
                        tests++;
                        if (q_r.size() == 0 || out_r !== q_r[0] || out_i !== q_i[0]
                            || out_idx !== 3'(got % 8) || out_last !== (got % 8 == 7)) begin
                            fails++;
                            $display("FAIL rand_out%0d: r=%0d i=%0d idx=%0d last=%b required %0d %0d %0d %b (queued %0d)",
                                     got, out_r, out_i, out_idx, out_last, (q_r.size() > 0) ? q_r[0] : 8'd0,
                                     (q_i.size() > 0) ? q_i[0] : 8'd0, got % 8, got % 8 == 7, q_r.size());
                        end
                        if (q_r.size() > 0) begin
                            void'(q_r.pop_front());
                            void'(q_i.pop_front());
                        end
                        got++;
                    end
                    cyc++;
                end
            end
        join
        tests++;
        if (got != NF * 8) begin
            fails++;
            $display("FAIL rand_count: got %0d results required %0d", got, NF * 8);
        end
        out_ready = 1'b1;
    endtask

`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
    task automatic test_pingpong();
        logic [W-1:0] rr [24];
        int           rc [24];
        logic [2:0]   ri [24];
        int got, cyc, guard;
        logic [W-1:0] er;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fork
            begin
                for (int s = 0; s < 24; s++) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_r = (s / 8 == 1) ? ((s % 8 == 0) ? 8'd1 : 8'd0) : 8'd1;
                    in_i = 8'd0;
                    #1;
                    if (s < 16) begin
                        tests++;
                        if (in_ready !== 1'b1) begin
                            fails++;
                            $display("FAIL pp_ready%0d: in_ready=%b required 1", s, in_ready);
                        end
                    end
                    guard = 0;
                    while (!in_ready && guard < 100) begin
                        @(negedge clk);
                        #1;
                        guard++;
                    end
                    @(posedge clk);
                end
                #1 in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                got = 0;
                cyc = 0;
                while (got < 24 && cyc < 200) begin
                    @(negedge clk);
                    #1;
                    if (out_valid) begin
                        rr[got] = out_r;
                        ri[got] = out_idx;
                        rc[got] = cyc;
                        got++;
                    end
                    cyc++;
                end
            end
        join
        tests++;
        if (got != 24) begin
            fails++;
            $display("FAIL pp_count: got %0d results required 24", got);
        end
        for (int j = 0; j < 24; j++) begin
            er = (j / 8 == 1) ? 8'd1 : ((j % 8 == 0) ? 8'd8 : 8'd0);
            tests++;
            if (rr[j] !== er || ri[j] !== 3'(j % 8)) begin
                fails++;
                $display("FAIL pp_out%0d: r=%0d idx=%0d required %0d %0d", j, rr[j], ri[j], er, j % 8);
            end
        end
        tests++;
        if (rc[7] - rc[0] != 7 || rc[8] - rc[7] != 2 || rc[16] - rc[15] != 2 || rc[23] - rc[16] != 7) begin
            fails++;
            $display("FAIL pp_spacing: %0d %0d %0d %0d required 7 2 2 7",
                     rc[7] - rc[0], rc[8] - rc[7], rc[16] - rc[15], rc[23] - rc[16]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        flush = 1'b0;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_dc();
        test_backpressure();
        test_flush();
        test_reset_mid_load();
        test_random();
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
        test_pingpong();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
